// File: rtl/bitonic_sort_seq_ctrl_if.sv
// Bus bundle for the sequential bitonic sort controller: upstream stream,
// downstream stream, external compare-exchange unit and status flags.
// The master side is the controller; the slave side is its environment.
interface bitonic_sort_seq_ctrl_if #(
    parameter int W = 32
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [W-1:0] cmp_din1;
    logic [W-1:0] cmp_din2;
    logic [W-1:0] cmp_big;
    logic [W-1:0] cmp_small;
    logic         busy;
    logic         sort_done;

    modport master (
        input  in_data, in_valid, out_ready, cmp_big, cmp_small,
        output in_ready, out_data, out_valid, out_last,
               cmp_din1, cmp_din2, busy, sort_done
    );

    modport slave (
        output in_data, in_valid, out_ready, cmp_big, cmp_small,
        input  in_ready, out_data, out_valid, out_last,
               cmp_din1, cmp_din2, busy, sort_done
    );
endinterface

// File: rtl/bitonic_sort_seq_ctrl.sv
// Sequential bitonic sort controller. Buffers N words, walks the bitonic
// network one compare-exchange per cycle through an external comparator,
// then streams the sorted block out. One block in flight at a time.
module bitonic_sort_seq_ctrl #(
    parameter int W     = 32,
    parameter int N     = 8,
    parameter int LOGN  = 3,
    parameter int ORDER = 0
) (
    input logic                   clk,
    input logic                   rst,
    bitonic_sort_seq_ctrl_if.master bus
);

    if (LOGN != $clog2(N) || N < 4 || (1 << LOGN) != N) begin : g_param_check
        $error("bitonic_sort_seq_ctrl: N must be a power of 2 >= 4 and LOGN == log2(N)");
    end

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    localparam int SW = $clog2(LOGN + 1);
    localparam int PW = LOGN - 1;

    typedef logic [LOGN-1:0] idx_t;
    typedef logic [SW-1:0]   lvl_t;

    state_t         state, state_nxt;
    logic           full;        // last word accepted, SORT starts next edge
    idx_t           ld_cnt;
    idx_t           rd_cnt;
    lvl_t           stage;       // k = 2 << stage
    lvl_t           jlog;        // j = 1 << jlog
    logic [PW-1:0]  pair;        // pair index within one (k, j) pass
    logic [W-1:0]   sbuf [N];

    idx_t           pair_ext, jmask, idx_lo, idx_hi;
    logic [LOGN:0]  kmask;
    logic           up, last_cmp, ld_fire, rd_fire;

    // Map (stage, jlog, pair) onto the partner indices of the current compare.
    always_comb begin
        pair_ext = idx_t'(pair);
        jmask    = (idx_t'(1) << jlog) - idx_t'(1);
        // Insert a 0 at bit position jlog: the lower partner of each pair.
        idx_lo   = ((pair_ext & ~jmask) << 1) | (pair_ext & jmask);
        idx_hi   = idx_lo | (idx_t'(1) << jlog);
        kmask    = (LOGN + 1)'(2) << stage;
        up       = (({1'b0, idx_lo} & kmask) == '0) ^ (ORDER != 0);
        last_cmp = (stage == lvl_t'(LOGN - 1)) && (jlog == '0) && (pair == '1);
        ld_fire  = (state == LOAD) && !full && bus.in_valid;
        rd_fire  = (state == DRAIN) && bus.out_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        case (state)
            LOAD:    if (full) state_nxt = SORT;
            SORT:    if (last_cmp) state_nxt = DRAIN;
            DRAIN:   if (rd_fire && rd_cnt == idx_t'(N - 1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Outputs decoded from state and counters only; reset forces the idle set.
    always_comb begin
        bus.in_ready  = (state == LOAD) && !full;
        bus.busy      = (state != LOAD);
        bus.sort_done = (state == SORT) && last_cmp;
        bus.out_valid = (state == DRAIN);
        bus.out_last  = (state == DRAIN) && (rd_cnt == idx_t'(N - 1));
        bus.out_data  = (state == DRAIN) ? sbuf[rd_cnt] : '0;
        bus.cmp_din1  = (state == SORT)  ? sbuf[idx_lo] : '0;
        bus.cmp_din2  = (state == SORT)  ? sbuf[idx_hi] : '0;
    end

    // Load/read counters and the network walk (k outer, j descending, i ascending).
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            full   <= 1'b0;
            ld_cnt <= '0;
            rd_cnt <= '0;
            stage  <= '0;
            jlog   <= '0;
            pair   <= '0;
        end else begin
            if (ld_fire) begin
                ld_cnt <= ld_cnt + idx_t'(1);
                if (ld_cnt == idx_t'(N - 1)) full <= 1'b1;
            end
            if (state == LOAD && full) full <= 1'b0;
            if (state == SORT) begin
                pair <= pair + PW'(1);
                if (pair == '1) begin
                    if (jlog != '0) begin
                        jlog <= jlog - lvl_t'(1);
                    end else if (stage == lvl_t'(LOGN - 1)) begin
                        stage <= '0;
                    end else begin
                        stage <= stage + lvl_t'(1);
                        jlog  <= stage + lvl_t'(1);
                    end
                end
            end
            if (rd_fire) rd_cnt <= rd_cnt + idx_t'(1);
        end
    end

    // Block buffer: written by loads and by each compare-exchange.
    always_ff @(posedge clk) begin
        // NOTE: the data buffer has no reset; every word is overwritten by a
        // load before it is read, so clearing it would only add reset fan-out.
        if (ld_fire) begin
            sbuf[ld_cnt] <= bus.in_data;
        end else if (state == SORT) begin
            sbuf[idx_lo] <= up ? bus.cmp_small : bus.cmp_big;
            sbuf[idx_hi] <= up ? bus.cmp_big   : bus.cmp_small;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_seq_ctrl.sv
// Directed bench for bitonic_sort_seq_ctrl: an ascending instance for the
// main stream tests and a descending instance for the comparator-order test.
module tb_bitonic_sort_seq_ctrl;
    localparam int W = 32;
    localparam int N = 8;
    localparam int LAT = 25;
    typedef logic [W-1:0] blk_t [N];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitonic_sort_seq_ctrl_if #(.W(W)) bus0 ();
    bitonic_sort_seq_ctrl_if #(.W(W)) bus1 ();

    bitonic_sort_seq_ctrl #(.W(W), .N(N), .LOGN(3), .ORDER(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    bitonic_sort_seq_ctrl #(.W(W), .N(N), .LOGN(3), .ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Comparator models: unsigned max/min, combinational.
    assign bus0.cmp_big   = (bus0.cmp_din1 > bus0.cmp_din2) ? bus0.cmp_din1 : bus0.cmp_din2;
    assign bus0.cmp_small = (bus0.cmp_din1 > bus0.cmp_din2) ? bus0.cmp_din2 : bus0.cmp_din1;
    assign bus1.cmp_big   = (bus1.cmp_din1 > bus1.cmp_din2) ? bus1.cmp_din1 : bus1.cmp_din2;
    assign bus1.cmp_small = (bus1.cmp_din1 > bus1.cmp_din2) ? bus1.cmp_din2 : bus1.cmp_din1;

    int n_vec = 0;
    int n_err = 0;
    int sd0 = 0;
    int sd1 = 0;
    logic log_en = 1'b0;
    logic [W-1:0] log_a [$];
    logic [W-1:0] log_b [$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Count sort_done pulses and log descending-instance comparator operands.
    always @(negedge clk) begin
        if (bus0.sort_done) sd0++;
        if (bus1.sort_done) sd1++;
        if (log_en && bus1.busy && !bus1.out_valid) begin
            log_a.push_back(bus1.cmp_din1);
            log_b.push_back(bus1.cmp_din2);
        end
    end

    function automatic logic get_in_ready(input bit sel);
        return sel ? bus1.in_ready : bus0.in_ready;
    endfunction
    function automatic logic get_out_valid(input bit sel);
        return sel ? bus1.out_valid : bus0.out_valid;
    endfunction
    function automatic logic get_out_last(input bit sel);
        return sel ? bus1.out_last : bus0.out_last;
    endfunction
    function automatic logic [W-1:0] get_out_data(input bit sel);
        return sel ? bus1.out_data : bus0.out_data;
    endfunction

    task automatic drive_in(input bit sel, input logic v, input logic [W-1:0] d);
        if (sel) begin
            bus1.in_valid = v;
            bus1.in_data  = d;
        end else begin
            bus0.in_valid = v;
            bus0.in_data  = d;
        end
    endtask

    task automatic set_out_ready(input bit sel, input logic v);
        if (sel) bus1.out_ready = v;
        else     bus0.out_ready = v;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present N words; optionally drop in_valid (with junk data) between them.
    task automatic load_block(input bit sel, input blk_t blk, input bit gap);
        for (int w = 0; w < N; w++) begin
            int tries = 0;
            drive_in(sel, 1'b1, blk[w]);
            while (!get_in_ready(sel) && tries < 50) begin
                step();
                tries++;
            end
            check($sformatf("in_ready before word %0d", w), W'(get_in_ready(sel)), W'(1));
            step();
            drive_in(sel, 1'b0, 32'hDEAD_BEEF);
            if (gap && w < N - 1) step();
        end
        check("in_ready after block", W'(get_in_ready(sel)), W'(0));
    endtask

    // Count edges from the last accept until out_valid appears.
    task automatic wait_out(input bit sel);
        int edges = 0;
        while (!get_out_valid(sel) && edges < 200) begin
            step();
            edges++;
        end
        check("first out_valid latency", W'(edges), W'(LAT));
    endtask

    // Drain one block; with toggle, out_ready alternates 1,0,1,0...
    task automatic drain(input bit sel, input blk_t exp, input bit toggle);
        int rd = 0;
        int cyc = 0;
        logic rdy;
        while (rd < N && cyc < 100) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            set_out_ready(sel, rdy);
            check($sformatf("out_valid c%0d", cyc), W'(get_out_valid(sel)), W'(1));
            check($sformatf("out_data w%0d c%0d", rd, cyc), get_out_data(sel), exp[rd]);
            check($sformatf("out_last w%0d c%0d", rd, cyc), W'(get_out_last(sel)), W'(rd == N - 1));
            if (rdy) rd++;
            step();
            cyc++;
        end
        set_out_ready(sel, 1'b0);
        check("drain word count", W'(rd), W'(N));
        check("drain cycle count", W'(cyc), toggle ? W'(2 * N - 1) : W'(N));
        check("out_valid after block", W'(get_out_valid(sel)), W'(0));
        check("in_ready after drain", W'(get_in_ready(sel)), W'(1));
    endtask

    // Reference walk of the bitonic network for the descending instance.
    task automatic check_pairs(input blk_t start);
        logic [W-1:0] m [N];
        logic [W-1:0] lo, hi;
        int p = 0;
        bit up;
        for (int q = 0; q < N; q++) m[q] = start[q];
        check("compare count", W'(log_a.size()), W'(24));
        for (int k = 2; k <= N; k *= 2) begin
            for (int j = k / 2; j > 0; j /= 2) begin
                for (int i = 0; i < N; i++) begin
                    int l = i ^ j;
                    if (l > i) begin
                        if (p < log_a.size()) begin
                            check($sformatf("cmp_din1 #%0d", p), log_a[p], m[i]);
                            check($sformatf("cmp_din2 #%0d", p), log_b[p], m[l]);
                        end
                        lo = (m[i] < m[l]) ? m[i] : m[l];
                        hi = (m[i] < m[l]) ? m[l] : m[i];
                        up = ((i & k) == 0) ^ 1'b1;
                        m[i] = up ? lo : hi;
                        m[l] = up ? hi : lo;
                        p++;
                    end
                end
            end
        end
    endtask

    initial begin
        blk_t vin, vexp, seq;
        rst = 1'b1;
        drive_in(1'b0, 1'b0, '0);
        drive_in(1'b1, 1'b0, '0);
        set_out_ready(1'b0, 1'b0);
        set_out_ready(1'b1, 1'b0);
        step();
        step();
        check("reset in_ready",  W'(bus0.in_ready),  W'(1));
        check("reset out_valid", W'(bus0.out_valid), W'(0));
        check("reset out_last",  W'(bus0.out_last),  W'(0));
        check("reset busy",      W'(bus0.busy),      W'(0));
        check("reset sort_done", W'(bus0.sort_done), W'(0));
        check("reset out_data",  bus0.out_data, '0);
        check("reset cmp_din1",  bus0.cmp_din1, '0);
        check("reset cmp_din2",  bus0.cmp_din2, '0);
        rst = 1'b0;
        step();

        seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

        // Reverse order, back to back, sink always ready.
        sd0 = 0;
        vin = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        load_block(1'b0, vin, 1'b0);
        wait_out(1'b0);
        drain(1'b0, seq, 1'b0);
        check("sort_done pulses", W'(sd0), W'(1));

        // Duplicates and the maximum value.
        vin  = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd3, 32'd3};
        vexp = '{32'd0, 32'd0, 32'd3, 32'd3, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFFF};
        load_block(1'b0, vin, 1'b0);
        wait_out(1'b0);
        drain(1'b0, vexp, 1'b0);

        // Already sorted input, sink stalls every other cycle.
        load_block(1'b0, seq, 1'b0);
        wait_out(1'b0);
        drain(1'b0, seq, 1'b1);

        // Source idles on alternate cycles with junk on in_data.
        vin  = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6};
        vexp = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd9};
        load_block(1'b0, vin, 1'b1);
        wait_out(1'b0);
        drain(1'b0, vexp, 1'b0);

        // Reset in the middle of SORT, then a fresh block.
        vin = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        load_block(1'b0, vin, 1'b0);
        repeat (11) step();
        check("mid-sort busy",      W'(bus0.busy),      W'(1));
        check("mid-sort out_valid", W'(bus0.out_valid), W'(0));
        rst = 1'b1;
        #1;
        check("abort out_valid", W'(bus0.out_valid), W'(0));
        check("abort busy",      W'(bus0.busy),      W'(0));
        check("abort in_ready",  W'(bus0.in_ready),  W'(1));
        check("abort cmp_din1",  bus0.cmp_din1, '0);
        check("abort cmp_din2",  bus0.cmp_din2, '0);
        step();
        rst = 1'b0;
        step();
        check("post-abort out_valid", W'(bus0.out_valid), W'(0));
        vin = '{32'd2, 32'd1, 32'd4, 32'd3, 32'd6, 32'd5, 32'd8, 32'd7};
        load_block(1'b0, vin, 1'b0);
        wait_out(1'b0);
        drain(1'b0, seq, 1'b0);

        // Descending instance with comparator operand log.
        sd1 = 0;
        log_a.delete();
        log_b.delete();
        log_en = 1'b1;
        load_block(1'b1, seq, 1'b0);
        wait_out(1'b1);
        log_en = 1'b0;
        vexp = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        drain(1'b1, vexp, 1'b0);
        check("descending sort_done pulses", W'(sd1), W'(1));
        check_pairs(seq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
